instr_fetch: RTL and testbench

Instruction fetch unit for the LEGv8 CPU. It owns the PC, issues one-at-a-time requests to instruction memory, and holds the fetched word for the decode/control stage. It presents opCode (instr[31:21]) to the control decoder. It computes the next PC from the BrTaken/UncondBr decisions that control and the datapath return for the held instruction.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/branch_target.sv | 34 +++
 rtl/instr_fetch.sv | 97 +++++++++
 tb/tb_instr_fetch.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared LEGv8 CPU types and instruction field positions.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } fetch_state_t;

  localparam int unsigned OPC_MSB     = 31;
  localparam int unsigned OPC_LSB     = 21;
  localparam int unsigned IMM26_MSB   = 25;
  localparam int unsigned IMM19_MSB   = 23;
  localparam int unsigned IMM19_LSB   = 5;
  localparam int unsigned INSTR_BYTES = 4;

  localparam int unsigned OPC_W   = OPC_MSB - OPC_LSB + 1;
  localparam int unsigned IMM26_W = IMM26_MSB + 1;
  localparam int unsigned IMM19_W = IMM19_MSB - IMM19_LSB + 1;

endpackage

// File: rtl/branch_target.sv
// Next-PC computation for B (imm26) and CB-type (imm19) branches, or sequential pc+4.
module branch_target
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 64
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [31:0]       instr,
  input  logic              BrTaken,
  input  logic              UncondBr,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] imm26_off;
  logic [ADDR_W-1:0] imm19_off;
  logic [ADDR_W-1:0] seq_pc;

  // Word offsets become byte offsets by appending two zero bits.
  assign imm26_off = {{(ADDR_W - IMM26_W - 2){instr[IMM26_MSB]}}, instr[IMM26_MSB:0], 2'b00};
  assign imm19_off = {{(ADDR_W - IMM19_W - 2){instr[IMM19_MSB]}},
                      instr[IMM19_MSB:IMM19_LSB], 2'b00};
  assign seq_pc    = pc + ADDR_W'(INSTR_BYTES);

  always_comb begin
    next_pc = seq_pc;
    if (BrTaken) begin
      next_pc = UncondBr ? (pc + imm26_off) : (pc + imm19_off);
    end
  end

  logic unused_instr;
  assign unused_instr = ^instr[31:IMM26_MSB+1];

endmodule

// File: rtl/instr_fetch.sv
// LEGv8 fetch unit: owns the PC, issues single outstanding imem requests, holds the word for decode.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned           ADDR_W   = 64,
  parameter logic [ADDR_W-1:0]     RESET_PC = '0,
  parameter int unsigned           CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [OPC_W-1:0]  opCode,
  output logic [ADDR_W-1:0] pc,
  input  logic              BrTaken,
  input  logic              UncondBr,
  input  logic              halt,
  output logic [CNT_W-1:0]  fetch_count
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] next_pc;

  branch_target #(
    .ADDR_W (ADDR_W)
  ) u_branch_target (
    .pc       (pc_q),
    .instr    (instr_q),
    .BrTaken  (BrTaken),
    .UncondBr (UncondBr),
    .next_pc  (next_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    instr_d        = instr_q;
    cnt_d          = cnt_q;
    imem_req_valid = 1'b0;
    instr_valid    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!halt) state_d = REQ;
      end
      REQ: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) state_d = WAIT;
      end
      // Only WAIT listens to the response bus, so stale responses are dropped.
      WAIT: begin
        if (imem_rsp_valid) begin
          instr_d = imem_rsp_data;
          state_d = HOLD;
        end
      end
      HOLD: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          cnt_d   = cnt_q + CNT_W'(1);
          pc_d    = next_pc;
          state_d = halt ? IDLE : REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign opCode      = instr_q[OPC_MSB:OPC_LSB];
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed plus randomized bench for instr_fetch against a PC/count reference model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [10:0] opCode;
  logic [63:0] pc;
  logic        BrTaken;
  logic        UncondBr;
  logic        halt;
  logic [31:0] fetch_count;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] m_pc;
  logic [31:0] m_cnt;

  instr_fetch #(
    .ADDR_W   (64),
    .RESET_PC (64'h0),
    .CNT_W    (32)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .opCode         (opCode),
    .pc             (pc),
    .BrTaken        (BrTaken),
    .UncondBr       (UncondBr),
    .halt           (halt),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference next PC using signed integer offsets in bytes.
  function automatic logic [63:0] ref_next(input logic [63:0] p, input logic [31:0] i,
                                           input logic br, input logic unc);
    longint off;
    if (!br) return p + 64'd4;
    if (unc) off = longint'($signed(i[25:0])) * 4;
    else     off = longint'($signed(i[23:5])) * 4;
    return p + 64'(off);
  endfunction

  // Starts in REQ; grants after gnt_wait cycles, responds rsp_wait cycles after grant.
  task automatic fetch(input logic [31:0] data, input int gnt_wait, input int rsp_wait);
    chk("req_valid", 64'(imem_req_valid), 64'd1);
    chk("req_addr", imem_addr, m_pc);
    imem_req_ready = 1'b0;
    for (int k = 0; k < gnt_wait; k++) begin
      imem_rsp_valid = 1'($urandom);
      imem_rsp_data  = $urandom;
      tick();
      chk("req_stall_valid", 64'(imem_req_valid), 64'd1);
      chk("req_stall_addr", imem_addr, m_pc);
      chk("req_stall_cnt", 64'(fetch_count), 64'(m_cnt));
    end
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    chk("wait_req_low", 64'(imem_req_valid), 64'd0);
    for (int k = 0; k < rsp_wait; k++) begin
      tick();
      chk("wait_ivalid_low", 64'(instr_valid), 64'd0);
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    tick();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    chk("hold_valid", 64'(instr_valid), 64'd1);
    chk("hold_instr", 64'(instr), 64'(data));
    chk("hold_opcode", 64'(opCode), 64'(data[31:21]));
    chk("hold_pc", pc, m_pc);
  endtask

  // Stalls decode, then accepts with the given branch decision and halt.
  task automatic accept(input logic br, input logic unc, input logic hlt, input int stall,
                        input logic [31:0] data);
    instr_ready = 1'b0;
    for (int k = 0; k < stall; k++) begin
      BrTaken        = 1'($urandom);
      UncondBr       = 1'($urandom);
      halt           = 1'($urandom);
      imem_rsp_valid = 1'($urandom);
      imem_rsp_data  = $urandom;
      tick();
      chk("stall_instr", 64'(instr), 64'(data));
      chk("stall_opcode", 64'(opCode), 64'(data[31:21]));
      chk("stall_pc", pc, m_pc);
      chk("stall_cnt", 64'(fetch_count), 64'(m_cnt));
    end
    imem_rsp_valid = 1'b0;
    instr_ready    = 1'b1;
    BrTaken        = br;
    UncondBr       = unc;
    halt           = hlt;
    tick();
    instr_ready = 1'b0;
    BrTaken     = 1'b0;
    UncondBr    = 1'b0;
    m_pc  = ref_next(m_pc, data, br, unc);
    m_cnt = m_cnt + 32'd1;
    chk("acc_cnt", 64'(fetch_count), 64'(m_cnt));
    chk("acc_pc", pc, m_pc);
    chk("acc_req", 64'(imem_req_valid), hlt ? 64'd0 : 64'd1);
  endtask

  initial begin
    logic [31:0] d;
    logic        br, unc, h;

    reset          = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    instr_ready    = 1'b0;
    BrTaken        = 1'b0;
    UncondBr       = 1'b0;
    halt           = 1'b0;
    m_pc           = 64'h0;
    m_cnt          = 32'h0;
    tick();
    tick();
    chk("rst_req", 64'(imem_req_valid), 64'd0);
    chk("rst_ivalid", 64'(instr_valid), 64'd0);
    chk("rst_instr", 64'(instr), 64'd0);
    chk("rst_pc", pc, 64'd0);
    chk("rst_cnt", 64'(fetch_count), 64'd0);
    reset = 1'b0;
    tick();

    // Sequential fetch, including request and decode backpressure.
    fetch(32'h91000421, 0, 0);
    chk("opcode_488", 64'(opCode), 64'h488);
    accept(1'b0, 1'b0, 1'b0, 0, 32'h91000421);
    chk("seq_addr4", imem_addr, 64'h4);
    chk("seq_cnt1", 64'(fetch_count), 64'd1);
    fetch(32'h91000421, 5, 0);
    accept(1'b0, 1'b0, 1'b0, 5, 32'h91000421);
    fetch(32'h91000421, 0, 2);
    accept(1'b0, 1'b0, 1'b0, 0, 32'h91000421);
    fetch(32'h91000421, 1, 1);
    accept(1'b0, 1'b0, 1'b0, 1, 32'h91000421);
    chk("seq_addr10", imem_addr, 64'h10);

    // Unconditional backward branch from 0x10 to 0x0, then forward to 0x20.
    fetch(32'h17FFFFFC, 0, 0);
    accept(1'b1, 1'b1, 1'b0, 0, 32'h17FFFFFC);
    chk("b_back_addr", imem_addr, 64'h0);
    fetch(32'h14000008, 0, 0);
    accept(1'b1, 1'b1, 1'b0, 0, 32'h14000008);
    chk("b_fwd_addr", imem_addr, 64'h20);

    // CBZ taken and not taken at 0x20.
    fetch(32'hB4000040, 0, 0);
    accept(1'b1, 1'b0, 1'b0, 0, 32'hB4000040);
    chk("cbz_taken", imem_addr, 64'h28);
    fetch(32'h17FFFFFE, 0, 0);
    accept(1'b1, 1'b1, 1'b0, 0, 32'h17FFFFFE);
    fetch(32'hB4000040, 0, 0);
    accept(1'b0, 1'b0, 1'b0, 0, 32'hB4000040);
    chk("cbz_not_taken", imem_addr, 64'h24);

    // halt raised after issue does not abort the fetch.
    halt = 1'b1;
    fetch(32'h91000421, 2, 2);
    accept(1'b0, 1'b0, 1'b0, 0, 32'h91000421);

    // Reset while waiting; a later stray response must be ignored.
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    reset = 1'b1;
    halt  = 1'b1;
    tick();
    reset = 1'b0;
    m_pc  = 64'h0;
    m_cnt = 32'h0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEADBEEF;
    tick();
    imem_rsp_valid = 1'b0;
    chk("stale_instr", 64'(instr), 64'd0);
    chk("stale_ivalid", 64'(instr_valid), 64'd0);
    chk("stale_req", 64'(imem_req_valid), 64'd0);
    chk("stale_cnt", 64'(fetch_count), 64'd0);
    halt = 1'b0;
    tick();
    chk("post_rst_req", 64'(imem_req_valid), 64'd1);
    chk("post_rst_addr", imem_addr, 64'h0);

    // PC wrap at the top of the address space with halt at accept.
    fetch(32'h17FFFFFF, 0, 0);
    accept(1'b1, 1'b1, 1'b0, 0, 32'h17FFFFFF);
    chk("top_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
    fetch(32'h91000421, 0, 0);
    accept(1'b0, 1'b0, 1'b1, 0, 32'h91000421);
    chk("wrap_pc", pc, 64'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("halt_idle_req", 64'(imem_req_valid), 64'd0);
    end
    halt = 1'b0;
    tick();
    chk("unhalt_req", 64'(imem_req_valid), 64'd1);
    chk("unhalt_addr", imem_addr, 64'h0);

    // Random instructions, branch decisions, latencies and halts.
    for (int n = 0; n < 150; n++) begin
      d   = $urandom;
      br  = 1'($urandom);
      unc = 1'($urandom);
      h   = ($urandom_range(0, 7) == 0);
      fetch(d, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      accept(br, unc, h, int'($urandom_range(0, 2)), d);
      if (h) begin
        for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
          tick();
          chk("rand_halt_req", 64'(imem_req_valid), 64'd0);
        end
        halt = 1'b0;
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
